// File: rtl/regfile_wr_sched.sv
// Write-port scheduler for the 32x32 register file.
// Zeroes every register after reset, then round-robins two write requesters.
module regfile_wr_sched #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 5,
  parameter int NUM_REGS      = 32,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              Enable,
  output logic [ADDR_W-1:0] wa3,
  output logic [DATA_W-1:0] Writein,
  output logic              init_busy
);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_REGS - 1);
  localparam state_t RST_ST = INIT_ON_RESET ? S_INIT : S_RUN;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              en_q, en_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [DATA_W-1:0] wd_q, wd_d;

  logic              run;
  logic              gnt0, gnt1;
  logic              xfer0, xfer1;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Contended cycles go to whoever was not served last.
  always_comb begin
    run   = (state_q == S_RUN) && !reset;
    gnt0  = req0_valid && (!req1_valid || last_q);
    gnt1  = req1_valid && (!req0_valid || !last_q);
    req0_ready = run && gnt0;
    req1_ready = run && gnt1;
    xfer0 = req0_valid && req0_ready;
    xfer1 = req1_valid && req1_ready;
    sel_addr = xfer1 ? req1_addr : req0_addr;
    sel_data = xfer1 ? req1_data : req0_data;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    en_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    case (state_q)
      S_INIT: begin
        en_d  = 1'b1;
        wa_d  = cnt_q[ADDR_W-1:0];
        wd_d  = '0;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (xfer0 || xfer1) begin
          last_d = xfer1;
          wa_d   = sel_addr;
          wd_d   = sel_data;
          // Register 0 is hardwired; accept the write but never strobe it.
          en_d   = (sel_addr != '0);
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RST_ST;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      en_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      en_q    <= en_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
    end
  end

  assign Enable    = en_q;
  assign wa3       = wa_q;
  assign Writein   = wd_q;
  assign init_busy = (state_q == S_INIT);

endmodule
